ipsxe_floating_point_one_loc_seq_v1_0: RTL and testbench
========================================================

IPSXE_FLOATING_POINT_ONE_LOC_SEQ_V1_0 -- requirements
Module: ipsxe_floating_point_one_loc_seq_v1_0

Interface
REQ-001 Parameter WIDTH, default 32, operand width; SHALL be a multiple of 8 in 16..64.
REQ-002 Parameter LOC_LAT, default 2, fixed latency in enabled cycles of the external 8-bit one-location unit.
REQ-003 Derived: NCH = WIDTH/8 chunks; PW = clog2(WIDTH) position width.
REQ-004 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_aclken  in  1  clock enable; when low, all state and outputs hold.
REQ-007 i_flush  in  1  synchronous abort; returns the block to IDLE and drops any result.
REQ-008 i_valid  in  1  operand valid.
REQ-009 o_ready  out  1  operand accept.
REQ-010 i_data  in  WIDTH  operand to scan for its leading one.
REQ-011 o_loc_data  out  8  chunk presented to the one-location unit.
REQ-012 i_loc_pos  in  3  leading-one index within the presented chunk.
REQ-013 i_loc_zero  in  1  presented chunk was all zero.
REQ-014 o_valid  out  1  result valid.
REQ-015 i_ready  in  1  result accept.
REQ-016 o_pos  out  PW  leading-one bit index in i_data.
REQ-017 o_zero  out  1  operand was all zero.
REQ-018 o_busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, DONE; only enabled cycles (i_aclken=1) advance it.
REQ-020 o_ready SHALL be 1 only in IDLE with i_flush=0.
REQ-021 Accept: i_valid & o_ready & i_aclken -> capture i_data, set chunk index j=0 (MSB chunk, bits WIDTH-1..WIDTH-8), go to ISSUE.
REQ-022 ISSUE: one cycle; o_loc_data = chunk j; clear wait counter; go to WAIT.
REQ-023 WAIT: o_loc_data holds chunk j; counter increments each enabled cycle; i_loc_pos and i_loc_zero are sampled only in the cycle the counter equals LOC_LAT.
REQ-024 Sample with i_loc_zero=0 -> o_pos = 8*(NCH-1-j) + i_loc_pos, o_zero=0, go to DONE.
REQ-025 Sample with i_loc_zero=1 and j<NCH-1 -> j=j+1, go to ISSUE.
REQ-026 Sample with i_loc_zero=1 and j=NCH-1 -> o_pos=0, o_zero=1, go to DONE.
REQ-027 DONE: o_valid=1; o_pos and o_zero hold stable until i_valid... until i_ready & i_aclken, then go to IDLE; no new operand is accepted in that cycle.
REQ-028 o_loc_data SHALL be 0 in IDLE and DONE.
REQ-029 Latency: hit in chunk j -> o_valid first high (j+1)*(LOC_LAT+1)+1 enabled cycles after the accept cycle (WIDTH=32, LOC_LAT=2: 4, 7, 10, 13); all-zero operand -> NCH*(LOC_LAT+1)+1 enabled cycles.
REQ-030 i_aclken low in any state: no sampling, no counter change, and o_valid, o_pos and o_loc_data hold.
REQ-031 i_flush & i_aclken in any state: go to IDLE, o_valid=0, result discarded; a flush coinciding with i_valid in IDLE wins, and the operand is not accepted.
REQ-032 i_loc_* values outside the sampling cycle SHALL be ignored.

Reset
REQ-033 While i_rst=1: state=IDLE, j=0, counter=0, o_valid=0, o_pos=0, o_zero=0, o_loc_data=0, o_busy=0; o_ready=1 after release.
REQ-034 Reset asserted mid-operation aborts the operation immediately; the captured operand is not resumed.

Verification (bench models the locator as a LOC_LAT-deep registered leading-one finder gated by i_aclken)
REQ-035 WIDTH=32, i_data=0x0080_0000 -> chunk 1 hit, o_pos=23, o_zero=0, o_valid 7 cycles after accept.
REQ-036 i_data=0 -> four chunks issued in order 0..3, o_zero=1, o_pos=0, o_valid at cycle 13.
REQ-037 i_data=0x8000_0001 with i_ready held low for 5 cycles -> o_pos=31 held stable, o_ready=0 until the DONE handshake completes.
REQ-038 i_aclken toggled 1/0 every cycle during i_data=0x0000_0100 -> o_pos=8, result identical to the ungated run, and the elapsed enabled-cycle count is 10.
REQ-039 i_flush in WAIT of chunk 2 and then a new operand 0x4000_0000 -> no o_valid for the flushed operand; the next result is o_pos=30.
REQ-040 i_rst pulsed in ISSUE -> all outputs are at their reset values the same cycle; a subsequent operand completes normally.

Source files
------------

// File: rtl/ipsxe_floating_point_one_loc_seq_v1_0_if.sv
// Bus bundle for the sequential leading-one locator.
//   slave  : the locator sequencer (operand in, chunk out, locator result in,
//            position result out)
//   master : the environment (operand source, 8-bit one-location unit,
//            result sink)
// Signals:
//   i_valid/o_ready/i_data          operand handshake
//   o_loc_data/i_loc_pos/i_loc_zero  external 8-bit one-location unit
//   o_valid/i_ready/o_pos/o_zero     result handshake
//   o_busy                           high whenever the sequencer is not idle
interface ipsxe_floating_point_one_loc_seq_v1_0_if #(
  parameter int WIDTH = 32,
  parameter int PW    = $clog2(WIDTH)
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_data;
  logic [7:0]       o_loc_data;
  logic [2:0]       i_loc_pos;
  logic             i_loc_zero;
  logic             o_valid;
  logic             i_ready;
  logic [PW-1:0]    o_pos;
  logic             o_zero;
  logic             o_busy;

  modport slave (
    input  i_valid, i_data, i_loc_pos, i_loc_zero, i_ready,
    output o_ready, o_loc_data, o_valid, o_pos, o_zero, o_busy
  );

  modport master (
    output i_valid, i_data, i_loc_pos, i_loc_zero, i_ready,
    input  o_ready, o_loc_data, o_valid, o_pos, o_zero, o_busy
  );
endinterface

// File: rtl/ipsxe_floating_point_one_loc_seq_v1_0.sv
// Sequential leading-one locator. A WIDTH-bit operand is scanned 8 bits at a
// time, MSB chunk first, through an external 8-bit one-location unit with a
// fixed LOC_LAT-cycle latency. The first non-zero chunk yields the bit index
// of the leading one; an all-zero operand reports o_zero.
// Ports:
//   i_clk     clock
//   i_rst     asynchronous active-high reset
//   i_aclken  clock enable; all state holds while low
//   i_flush   synchronous abort back to IDLE
//   bus       slave side of ipsxe_floating_point_one_loc_seq_v1_0_if
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for an operand, o_ready high unless flushing
// ST_ISSUE | chunk j presented to the locator for its first cycle
// ST_WAIT  | chunk j held, counting locator latency, sample at LOC_LAT
// ST_DONE  | result valid, waiting for i_ready
module ipsxe_floating_point_one_loc_seq_v1_0 #(
  parameter int WIDTH   = 32,
  parameter int LOC_LAT = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_aclken,
  input  logic i_flush,
  ipsxe_floating_point_one_loc_seq_v1_0_if.slave bus
);

  localparam int NCH = WIDTH / 8;
  localparam int PW  = $clog2(WIDTH);
  localparam int JW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW  = $clog2(LOC_LAT + 1);

  localparam logic [JW-1:0] LAST_J = JW'(NCH - 1);
  localparam logic [CW-1:0] LAT_C  = CW'(LOC_LAT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic [JW-1:0]    j_q;
  logic [CW-1:0]    cnt_q;
  logic [7:0]       loc_data_q;
  logic             valid_q;
  logic [PW-1:0]    pos_q;
  logic             zero_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      j_q        <= '0;
      cnt_q      <= '0;
      loc_data_q <= '0;
      valid_q    <= 1'b0;
      pos_q      <= '0;
      zero_q     <= 1'b0;
    end else if (i_aclken) begin
      if (i_flush) begin
        state_q    <= ST_IDLE;
        j_q        <= '0;
        cnt_q      <= '0;
        loc_data_q <= '0;
        valid_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.i_valid) begin
              // data_q is kept left-aligned so the current chunk is always
              // its top byte; o_loc_data is registered to match.
              data_q     <= bus.i_data;
              loc_data_q <= bus.i_data[WIDTH-1 -: 8];
              j_q        <= '0;
              state_q    <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            // The ISSUE cycle is the first cycle of locator latency, so the
            // count restarts at 1 and the result is sampled LOC_LAT cycles
            // after the chunk first appears.
            cnt_q   <= CW'(1);
            state_q <= ST_WAIT;
          end
          ST_WAIT: begin
            if (cnt_q == LAT_C) begin
              if (!bus.i_loc_zero) begin
                pos_q      <= PW'(8 * (NCH - 1 - int'(j_q)) + int'(bus.i_loc_pos));
                zero_q     <= 1'b0;
                valid_q    <= 1'b1;
                loc_data_q <= '0;
                state_q    <= ST_DONE;
              end else if (j_q == LAST_J) begin
                pos_q      <= '0;
                zero_q     <= 1'b1;
                valid_q    <= 1'b1;
                loc_data_q <= '0;
                state_q    <= ST_DONE;
              end else begin
                j_q        <= j_q + JW'(1);
                data_q     <= data_q << 8;
                loc_data_q <= data_q[WIDTH-9 -: 8];
                state_q    <= ST_ISSUE;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          ST_DONE: begin
            if (bus.i_ready) begin
              valid_q <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.o_ready    = (state_q == ST_IDLE) && !i_flush;
  assign bus.o_busy     = (state_q != ST_IDLE);
  assign bus.o_loc_data = loc_data_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_pos      = pos_q;
  assign bus.o_zero     = zero_q;

endmodule

// File: tb/tb_ipsxe_floating_point_one_loc_seq_v1_0.sv
// Self-checking bench for ipsxe_floating_point_one_loc_seq_v1_0 (WIDTH=32,
// LOC_LAT=2). The one-location unit is modelled as a LOC_LAT-deep registered
// leading-one finder advanced only on enabled cycles.
module tb_ipsxe_floating_point_one_loc_seq_v1_0;

  localparam int WIDTH   = 32;
  localparam int LOC_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  logic aclken;
  logic flush;

  always #5 clk = ~clk;

  ipsxe_floating_point_one_loc_seq_v1_0_if #(.WIDTH(WIDTH)) bus ();

  ipsxe_floating_point_one_loc_seq_v1_0 #(
    .WIDTH   (WIDTH),
    .LOC_LAT (LOC_LAT)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_aclken (aclken),
    .i_flush  (flush),
    .bus      (bus)
  );

  // locator model: {zero, pos}
  function automatic logic [3:0] lof(input logic [7:0] d);
    logic [3:0] r;
    r = 4'b1000;
    for (int b = 0; b < 8; b++) begin
      if (d[b]) r = {1'b0, 3'(b)};
    end
    return r;
  endfunction

  logic [3:0] pipe [LOC_LAT];

  initial begin
    for (int k = 0; k < LOC_LAT; k++) pipe[k] = 4'b1000;
  end

  always @(posedge clk) begin
    if (aclken) begin
      pipe[0] <= lof(bus.o_loc_data);
      for (int k = 1; k < LOC_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign bus.i_loc_zero = pipe[LOC_LAT-1][3];
  assign bus.i_loc_pos  = pipe[LOC_LAT-1][2:0];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operand from accept to result handshake. hold = cycles i_ready stays
  // low in DONE; gate = toggle i_aclken every cycle while the scan runs.
  task automatic run_op(input logic [31:0] d, input int ep, input bit ez,
                        input int elat, input int hold, input bit gate,
                        input string nm);
    int  lat;
    int  n;
    bit  en;
    chk({nm, " ready_idle"}, 64'(bus.o_ready), 64'd1);
    aclken      = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    tick();
    bus.i_valid = 1'b0;
    chk({nm, " busy_after_accept"}, 64'(bus.o_busy), 64'd1);
    lat = 1;
    n   = 0;
    while (!bus.o_valid && n < 200) begin
      if (gate) aclken = ~aclken;
      en = aclken;
      tick();
      if (en) lat++;
      n++;
    end
    chk({nm, " valid_seen"}, 64'(bus.o_valid), 64'd1);
    chk({nm, " latency"}, 64'(lat), 64'(elat));
    chk({nm, " pos"}, 64'(bus.o_pos), 64'(ep));
    chk({nm, " zero"}, 64'(bus.o_zero), 64'(ez));
    chk({nm, " ready_in_done"}, 64'(bus.o_ready), 64'd0);
    chk({nm, " loc_data_in_done"}, 64'(bus.o_loc_data), 64'd0);
    if (gate) begin
      aclken      = 1'b0;
      bus.i_ready = 1'b1;
      tick();
      bus.i_ready = 1'b0;
      chk({nm, " gated_ready_ignored"}, 64'(bus.o_valid), 64'd1);
      chk({nm, " gated_pos_hold"}, 64'(bus.o_pos), 64'(ep));
    end
    aclken = 1'b1;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({nm, " hold_valid"}, 64'(bus.o_valid), 64'd1);
      chk({nm, " hold_pos"}, 64'(bus.o_pos), 64'(ep));
      chk({nm, " hold_ready"}, 64'(bus.o_ready), 64'd0);
    end
    // an operand offered during the DONE handshake must not be taken
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data  = 32'hFFFF_FFFF;
    tick();
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b0;
    chk({nm, " valid_dropped"}, 64'(bus.o_valid), 64'd0);
    chk({nm, " no_accept_on_done"}, 64'(bus.o_busy), 64'd0);
    chk({nm, " ready_back"}, 64'(bus.o_ready), 64'd1);
  endtask

  typedef struct {
    logic [31:0] data;
    int          pos;
    bit          zero;
    int          lat;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_valid;

    vecs[0] = '{32'h0080_0000, 23, 1'b0, 7};
    vecs[1] = '{32'h0000_0000,  0, 1'b1, 13};
    vecs[2] = '{32'h8000_0001, 31, 1'b0, 4};
    vecs[3] = '{32'h0000_0100,  8, 1'b0, 10};
    vecs[4] = '{32'h0000_0001,  0, 1'b0, 13};
    vecs[5] = '{32'h0000_00FF,  7, 1'b0, 13};
    vecs[6] = '{32'h4000_0000, 30, 1'b0, 4};
    vecs[7] = '{32'h0001_2345, 16, 1'b0, 7};
    vecs[8] = '{32'h00F0_0000, 23, 1'b0, 7};
    vecs[9] = '{32'h0000_8000, 15, 1'b0, 10};

    rst         = 1'b1;
    aclken      = 1'b1;
    flush       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;
    repeat (3) tick();
    chk("rst valid", 64'(bus.o_valid), 64'd0);
    chk("rst pos", 64'(bus.o_pos), 64'd0);
    chk("rst zero", 64'(bus.o_zero), 64'd0);
    chk("rst loc_data", 64'(bus.o_loc_data), 64'd0);
    chk("rst busy", 64'(bus.o_busy), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst ready", 64'(bus.o_ready), 64'd1);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].data, vecs[i].pos, vecs[i].zero, vecs[i].lat, 0, 1'b0,
             $sformatf("vec%0d", i));
    end

    // result held while the sink stalls
    run_op(32'h8000_0001, 31, 1'b0, 4, 5, 1'b0, "stall");

    // clock enable toggling every cycle
    run_op(32'h0000_0100, 8, 1'b0, 10, 0, 1'b1, "gated");

    // flush during WAIT of chunk 2
    bus.i_valid = 1'b1;
    bus.i_data  = 32'h0000_0000;
    tick();
    bus.i_valid = 1'b0;
    repeat (7) tick();
    chk("flush busy_before", 64'(bus.o_busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy", 64'(bus.o_busy), 64'd0);
    chk("flush valid", 64'(bus.o_valid), 64'd0);
    chk("flush loc_data", 64'(bus.o_loc_data), 64'd0);
    saw_valid = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (bus.o_valid) saw_valid = 1'b1;
    end
    chk("flush no_result", 64'(saw_valid), 64'd0);
    run_op(32'h4000_0000, 30, 1'b0, 4, 0, 1'b0, "after_flush");

    // flush beats a simultaneous operand in IDLE
    flush       = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data  = 32'h0000_0100;
    #1;
    chk("flush_idle ready", 64'(bus.o_ready), 64'd0);
    tick();
    flush       = 1'b0;
    bus.i_valid = 1'b0;
    chk("flush_idle not_accepted", 64'(bus.o_busy), 64'd0);

    // reset pulse in ISSUE
    bus.i_valid = 1'b1;
    bus.i_data  = 32'h1200_0000;
    tick();
    bus.i_valid = 1'b0;
    chk("issue loc_data", 64'(bus.o_loc_data), 64'h12);
    chk("issue busy", 64'(bus.o_busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid busy", 64'(bus.o_busy), 64'd0);
    chk("rst_mid loc_data", 64'(bus.o_loc_data), 64'd0);
    chk("rst_mid valid", 64'(bus.o_valid), 64'd0);
    chk("rst_mid pos", 64'(bus.o_pos), 64'd0);
    #2;
    rst = 1'b0;
    tick();
    chk("rst_mid stays_idle", 64'(bus.o_busy), 64'd0);
    run_op(32'h1200_0000, 28, 1'b0, 4, 0, 1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
